// File: rtl/vx_gpu_pkg.sv
// vx_gpu_pkg
// Shared types and helpers for the mul/div sharing arbiter.
// Contents:
//   PEND_W      : width of a per-requester outstanding-request counter.
//   pend_cnt_t  : outstanding-request counter type.
//   perf_cnt_t  : 32-bit wrapping performance counter type.
//   tag_width() : requester-index (tag) width for a given requester count.
//                 Never less than one bit.
package vx_gpu_pkg;

  localparam int PEND_W = 4;

  typedef logic [PEND_W-1:0] pend_cnt_t;
  typedef logic [31:0]       perf_cnt_t;

  // Tag width = max(1, clog2(num_reqs)); a single requester still carries a 1-bit tag
  function automatic int tag_width(input int num_reqs);
    int w;
    if (num_reqs > 1) begin
      w = $clog2(num_reqs);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/vx_mdv_share_arb_chk.sv
// vx_mdv_share_arb_chk
// Simulation checks for the response path of vx_mdv_share_arb.
// Ports:
//   clk, reset   in  1  clock / asynchronous active-high reset
//   tag_oob      in  1  a response is presented with a tag beyond NUM_REQS-1
//   underflow    in  1  a response handshake targets a requester with nothing pending
module vx_mdv_share_arb_chk (
  input logic clk,
  input logic reset,
  input logic tag_oob,
  input logic underflow
);

  a_rsp_tag_in_range: assert property (@(posedge clk) disable iff (reset) !tag_oob);

  a_rsp_no_underflow: assert property (@(posedge clk) disable iff (reset) !underflow);

endmodule

// File: rtl/vx_rr_select.sv
// vx_rr_select
// Round-robin one-of-N picker. The search starts at rr_ptr and wraps, so the
// requester at rr_ptr has the highest priority.
// Ports:
//   valid_in    in  NUM_REQS  eligible requesters
//   rr_ptr      in  TAG_W     first index to consider
//   grant_oh    out NUM_REQS  one-hot winner (zero when nobody is eligible)
//   grant_idx   out TAG_W     binary winner index (0 when nobody is eligible)
//   grant_valid out 1         some requester won
module vx_rr_select
  import vx_gpu_pkg::*;
#(
  parameter  int NUM_REQS = 2,
  localparam int TAG_W    = tag_width(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid_in,
  input  logic [TAG_W-1:0]    rr_ptr,
  output logic [NUM_REQS-1:0] grant_oh,
  output logic [TAG_W-1:0]    grant_idx,
  output logic                grant_valid
);

  // Scan from the pointer with wrap-around and take the first eligible index
  always_comb begin : p_select
    int idx;
    idx         = 0;
    grant_oh    = {NUM_REQS{1'b0}};
    grant_idx   = {TAG_W{1'b0}};
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (!grant_valid && valid_in[idx]) begin
        grant_valid   = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = TAG_W'(idx);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/vx_mdv_share_arb.sv
// vx_mdv_share_arb
// Shares one mul/div unit among NUM_REQS ALU blocks. Requests are picked
// round-robin into a one-entry output register (1-cycle latency, one request
// per cycle). Each requester may have at most MAX_PENDING requests in flight.
// Responses are steered back combinationally by tag.
// Optional feature: define VX_MDV_ARB_PERF_EN to add perf_stall_cycles.
// Ports:
//   clk, reset            clock / asynchronous active-high reset
//   req_valid_in/data_in  per-requester requests (requester i at [i*DATAW +: DATAW])
//   req_ready_out         one-hot accept for the granted requester
//   unit_req_*            registered request to the shared unit (tag = requester index)
//   unit_rsp_*            response from the shared unit
//   rsp_valid_out         one-hot response valid, rsp_data_out broadcast
//   rsp_ready_in          per-requester response ready
//   busy                  a request is buffered or outstanding
//   perf_stall_cycles     (VX_MDV_ARB_PERF_EN only) cycles with a request but no grant
module vx_mdv_share_arb
  import vx_gpu_pkg::*;
#(
  parameter  int NUM_REQS    = 2,
  parameter  int DATAW       = 128,
  parameter  int RSP_DATAW   = 128,
  parameter  int MAX_PENDING = 4,
  localparam int TAG_W       = tag_width(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid_in,
  input  logic [NUM_REQS*DATAW-1:0] req_data_in,
  output logic [NUM_REQS-1:0]       req_ready_out,
  output logic                      unit_req_valid,
  output logic [DATAW-1:0]          unit_req_data,
  output logic [TAG_W-1:0]          unit_req_tag,
  input  logic                      unit_req_ready,
  input  logic                      unit_rsp_valid,
  input  logic [RSP_DATAW-1:0]      unit_rsp_data,
  input  logic [TAG_W-1:0]          unit_rsp_tag,
  output logic                      unit_rsp_ready,
  output logic [NUM_REQS-1:0]       rsp_valid_out,
  output logic [RSP_DATAW-1:0]      rsp_data_out,
  input  logic [NUM_REQS-1:0]       rsp_ready_in,
  output logic                      busy
`ifdef VX_MDV_ARB_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles
`endif
);

  localparam pend_cnt_t         MAX_PEND = pend_cnt_t'(MAX_PENDING);
  localparam logic [TAG_W-1:0]  LAST_IDX = TAG_W'(NUM_REQS - 1);

  logic                reg_valid_r;
  logic [DATAW-1:0]    reg_data_r;
  logic [TAG_W-1:0]    reg_tag_r;
  logic [TAG_W-1:0]    rr_ptr_r;
  pend_cnt_t           pending_r [NUM_REQS];

  logic [NUM_REQS-1:0] eligible_s;
  logic [NUM_REQS-1:0] pend_nz_s;
  logic [NUM_REQS-1:0] rsp_dec_s;
  logic [NUM_REQS-1:0] grant_oh_s;
  logic [TAG_W-1:0]    grant_idx_s;
  logic                grant_any_s;
  logic                accept_s;
  logic                grant_s;
  logic                tag_in_range_s;
  logic                rsp_fire_s;
  logic                tag_oob_s;
  logic                underflow_s;

  // Eligibility: request present and below the outstanding limit
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      pend_nz_s[i]  = |pending_r[i];
      eligible_s[i] = req_valid_in[i] && (pending_r[i] < MAX_PEND);
    end
  end

  vx_rr_select #(
    .NUM_REQS (NUM_REQS)
  ) u_rr_select (
    .valid_in    (eligible_s),
    .rr_ptr      (rr_ptr_r),
    .grant_oh    (grant_oh_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_any_s)
  );

  // The register can take a new request when empty or when the unit drains it this cycle
  assign accept_s      = !reg_valid_r || unit_req_ready;
  assign grant_s       = accept_s && grant_any_s;
  assign req_ready_out = grant_s ? grant_oh_s : {NUM_REQS{1'b0}};

  // Output request register; holds while the unit stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_valid_r <= 1'b0;
      reg_data_r  <= {DATAW{1'b0}};
      reg_tag_r   <= {TAG_W{1'b0}};
    end else if (grant_s) begin
      reg_valid_r <= 1'b1;
      reg_data_r  <= req_data_in[int'(grant_idx_s)*DATAW +: DATAW];
      reg_tag_r   <= grant_idx_s;
    end else if (unit_req_ready) begin
      reg_valid_r <= 1'b0;
    end else begin
      reg_valid_r <= reg_valid_r;
    end
  end

  // Round-robin pointer: next search starts just after the last winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= {TAG_W{1'b0}};
    end else if (grant_s) begin
      rr_ptr_r <= (grant_idx_s == LAST_IDX) ? {TAG_W{1'b0}} : grant_idx_s + TAG_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign unit_req_valid = reg_valid_r;
  assign unit_req_data  = reg_data_r;
  assign unit_req_tag   = reg_tag_r;

  // Response steering; out-of-range tags are swallowed so the unit never blocks
  always_comb begin
    rsp_valid_out  = {NUM_REQS{1'b0}};
    unit_rsp_ready = 1'b1;
    underflow_s    = 1'b0;
    tag_in_range_s = int'(unit_rsp_tag) < NUM_REQS;
    if (tag_in_range_s) begin
      rsp_valid_out[unit_rsp_tag] = unit_rsp_valid;
      unit_rsp_ready              = rsp_ready_in[unit_rsp_tag];
      underflow_s                 = unit_rsp_valid && rsp_ready_in[unit_rsp_tag]
                                    && !pend_nz_s[unit_rsp_tag];
    end else begin
      unit_rsp_ready = 1'b1;
    end
  end

  assign rsp_data_out = unit_rsp_data;
  assign rsp_fire_s   = unit_rsp_valid && unit_rsp_ready && tag_in_range_s;
  assign tag_oob_s    = unit_rsp_valid && !tag_in_range_s;

  // Per-requester decrement, suppressed at zero so the counter cannot wrap
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_dec_s[i] = rsp_fire_s && (int'(unit_rsp_tag) == i) && pend_nz_s[i];
    end
  end

  // Outstanding counters: +1 on grant, -1 on response, unchanged when both
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        pending_r[i] <= {PEND_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        case ({grant_s && grant_oh_s[i], rsp_dec_s[i]})
          2'b10:   pending_r[i] <= pending_r[i] + pend_cnt_t'(1);
          2'b01:   pending_r[i] <= pending_r[i] - pend_cnt_t'(1);
          default: pending_r[i] <= pending_r[i];
        endcase
      end
    end
  end

  assign busy = reg_valid_r || (|pend_nz_s);

`ifdef VX_MDV_ARB_PERF_EN
  perf_cnt_t stall_cnt_r;

  // Stall counter: some requester waiting and nobody granted; wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if ((|req_valid_in) && !grant_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign perf_stall_cycles = stall_cnt_r;
`endif

  vx_mdv_share_arb_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .tag_oob   (tag_oob_s),
    .underflow (underflow_s)
  );

endmodule
